// File: rtl/fullchip_seq_ctrl.sv
// Instruction sequencer for the single-core attention datapath.
// Collects Q then K vectors from the host, then drives one full pass:
// Q/K memory writes, K load into the array, execute, ofifo -> pmem move
// and per-row SFP normalisation with write-back. inst and mem_in are
// registered: the decision made in a cycle appears after the next edge.
module fullchip_seq_ctrl #(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int k_gap       = 2,
  parameter int exec_wait   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [pr*bw-1:0] in_data,
  output logic             in_ready,
  output logic [pr*bw-1:0] mem_in,
  output logic [18:0]      inst,
  output logic             busy,
  output logic             done,
  output logic [3:0]       phase
);

  // inst bit positions
  localparam int I_SFP_DIV  = 18;
  localparam int I_SFP_ACC  = 17;
  localparam int I_OFIFO_RD = 16;
  localparam int I_EXECUTE  = 7;
  localparam int I_LOAD     = 6;
  localparam int I_QMEM_RD  = 5;
  localparam int I_QMEM_WR  = 4;
  localparam int I_KMEM_RD  = 3;
  localparam int I_KMEM_WR  = 2;
  localparam int I_PMEM_RD  = 1;
  localparam int I_PMEM_WR  = 0;

  // Terminal counts for the 5-bit phase counter
  localparam logic [4:0] TC_LAST    = 5'(total_cycle - 1);
  localparam logic [4:0] COL_LAST   = 5'(col - 1);
  localparam logic [4:0] KLOAD_LAST = 5'(col + 1);
  localparam logic [4:0] GAP_LAST   = 5'(k_gap - 1);
  localparam logic [4:0] WAIT_LAST  = 5'(exec_wait - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_QWR   = 4'd1,
    S_KWR   = 4'd2,
    S_GAP   = 4'd3,
    S_KLOAD = 4'd4,
    S_WAIT1 = 4'd5,
    S_EXEC  = 4'd6,
    S_WAIT2 = 4'd7,
    S_OFIFO = 4'd8,
    S_SFP   = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  state_t           state_reg, state_next;
  logic [4:0]       cnt_reg, cnt_next;    // index within the current phase (row index in SFP)
  logic [2:0]       step_reg, step_next;  // SFP sub-step 0..4 within a row
  logic [18:0]      inst_reg, inst_next;
  logic [pr*bw-1:0] mem_in_reg, mem_in_next;
  logic             handshake;

  // Stream acceptance is purely a function of state, so no path from in_valid
  assign in_ready  = (state_reg == S_QWR) || (state_reg == S_KWR);
  assign handshake = in_valid && in_ready;
  assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done      = (state_reg == S_DONE);
  assign phase     = state_reg;
  assign inst      = inst_reg;
  assign mem_in    = mem_in_reg;

  // State, counters and output registers; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      step_reg   <= '0;
      inst_reg   <= '0;
      mem_in_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      step_reg   <= step_next;
      inst_reg   <= inst_next;
      mem_in_reg <= mem_in_next;
    end
  end

  // Next-state and next-instruction decode
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    step_next   = step_reg;
    inst_next   = '0;
    mem_in_next = mem_in_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_QWR;
          cnt_next   = '0;
          step_next  = '0;
        end
      end
      S_QWR: begin
        if (handshake) begin
          inst_next[I_QMEM_WR] = 1'b1;
          inst_next[15:12]     = cnt_reg[3:0];
          mem_in_next          = in_data;
          if (cnt_reg == TC_LAST) begin
            state_next = S_KWR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 5'd1;
          end
        end
      end
      S_KWR: begin
        if (handshake) begin
          inst_next[I_KMEM_WR] = 1'b1;
          inst_next[15:12]     = cnt_reg[3:0];
          mem_in_next          = in_data;
          if (cnt_reg == COL_LAST) begin
            state_next = (k_gap == 0) ? S_KLOAD : S_GAP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 5'd1;
          end
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = S_KLOAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      S_KLOAD: begin
        // One leading and one trailing load-only cycle frame the K reads
        inst_next[I_LOAD] = 1'b1;
        if (cnt_reg != 5'd0 && cnt_reg != KLOAD_LAST) begin
          inst_next[I_KMEM_RD] = 1'b1;
          inst_next[15:12]     = 4'(cnt_reg - 5'd1);
        end
        if (cnt_reg == KLOAD_LAST) begin
          state_next = (exec_wait == 0) ? S_EXEC : S_WAIT1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      S_WAIT1, S_WAIT2: begin
        if (cnt_reg == WAIT_LAST) begin
          state_next = (state_reg == S_WAIT1) ? S_EXEC : S_OFIFO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      S_EXEC: begin
        inst_next[I_EXECUTE] = 1'b1;
        inst_next[I_QMEM_RD] = 1'b1;
        inst_next[15:12]     = cnt_reg[3:0];
        if (cnt_reg == TC_LAST) begin
          state_next = (exec_wait == 0) ? S_OFIFO : S_WAIT2;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      S_OFIFO: begin
        inst_next[I_OFIFO_RD] = 1'b1;
        inst_next[I_PMEM_WR]  = 1'b1;
        inst_next[11:8]       = cnt_reg[3:0];
        if (cnt_reg == TC_LAST) begin
          state_next = S_SFP;
          cnt_next   = '0;
          step_next  = '0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      S_SFP: begin
        // Per row: read, accumulate, two divide cycles, then write back
        inst_next[11:8] = cnt_reg[3:0];
        case (step_reg)
          3'd0: inst_next[I_PMEM_RD] = 1'b1;
          3'd1: begin
            inst_next[I_PMEM_RD] = 1'b1;
            inst_next[I_SFP_ACC] = 1'b1;
          end
          3'd2, 3'd3: begin
            inst_next[I_PMEM_RD] = 1'b1;
            inst_next[I_SFP_DIV] = 1'b1;
          end
          default: begin
            inst_next[I_PMEM_WR] = 1'b1;
            inst_next[I_SFP_DIV] = 1'b1;
          end
        endcase
        if (step_reg == 3'd4) begin
          step_next = '0;
          if (cnt_reg == TC_LAST) begin
            state_next = S_DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 5'd1;
          end
        end else begin
          step_next = step_reg + 3'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        step_next  = '0;
      end
    endcase
  end

endmodule
